// File: rtl/dec_key_schedule.sv
// ---------------------------------------------------------------------------
// dec_key_schedule
//   AES-128 key schedule for a decryption datapath. A cipher key is expanded
//   once into eleven round keys (one expansion step per cycle). The keys are
//   then streamed out in reverse order, round 10 first and round 0 last.
//   Decryption consumes the keys in that order.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     key_valid  cipher key offered on key
//     key        128-bit cipher key, byte 0 in [127:120]
//     key_ready  block is idle and will take a key this cycle
//     rk_valid   round key presented on rk
//     rk_ready   round datapath takes rk this cycle
//     rk         round key, same byte order as key
//     rk_round   index of the key on rk (10 down to 0)
//     rk_last    marks round key 0
//
// sub_bytes
//   Forward AES S-box applied independently to NB bytes.
//
//   Ports
//     din        NB input bytes
//     dout       NB substituted bytes
// ---------------------------------------------------------------------------

module sub_bytes #(
    parameter int NB = 4
) (
    input  logic [8*NB-1:0] din,
    output logic [8*NB-1:0] dout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            assign dout[8*gi +: 8] = SBOX[din[8*gi +: 8]];
        end
    endgenerate

endmodule

module dec_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [127:0] key,
    output logic         key_ready,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk,
    output logic [3:0]   rk_round,
    output logic         rk_last
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        STREAM
    } state_t;

    state_t       state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic [3:0]   idx_reg, idx_next;
    // Copy of the most recently written round key. Each expansion step reads
    // this register directly, so no 11:1 mux sits in front of the S-boxes.
    logic [127:0] work_reg;
    logic [127:0] rk_mem [0:NR];

    logic         load;
    logic         step;
    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w, sub_w;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] next_rk;

    assign load = (state_reg == IDLE) && key_valid;
    assign step = (state_reg == EXPAND);

    // One FIPS-197 expansion step: round key cnt from round key cnt-1.
    assign {w0, w1, w2, w3} = work_reg;
    assign rot_w = {w3[23:0], w3[31:24]};

    sub_bytes #(.NB(4)) u_sub_word (
        .din  (rot_w),
        .dout (sub_w)
    );

    always_comb begin
        case (cnt_reg)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign nw0     = w0 ^ sub_w ^ {rcon, 24'h000000};
    assign nw1     = w1 ^ nw0;
    assign nw2     = w2 ^ nw1;
    assign nw3     = w3 ^ nw2;
    assign next_rk = {nw0, nw1, nw2, nw3};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (key_valid) begin
                    state_next = EXPAND;
                    cnt_next   = 4'd1;
                end
            end
            EXPAND: begin
                if (cnt_reg == LAST_RND) begin
                    state_next = STREAM;
                    idx_next   = LAST_RND;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            STREAM: begin
                if (rk_ready) begin
                    if (idx_reg == 4'd0) begin
                        state_next = IDLE;
                    end else begin
                        idx_next = idx_reg - 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            idx_reg   <= 4'd0;
            work_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
            if (load) begin
                work_reg <= key;
            end else if (step) begin
                work_reg <= next_rk;
            end
        end
    end

    // Round-key storage; entry 0 is the cipher key itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                rk_mem[i] <= '0;
            end
        end else begin
            if (load) begin
                rk_mem[0] <= key;
            end
            if (step) begin
                for (int i = 1; i <= NR; i++) begin
                    if (cnt_reg == 4'(i)) begin
                        rk_mem[i] <= next_rk;
                    end
                end
            end
        end
    end

    // The FSM is forced to IDLE asynchronously, so key_ready is also gated by
    // rst_n to stay low while reset is held.
    assign key_ready = rst_n && (state_reg == IDLE);
    assign rk_valid  = (state_reg == STREAM);
    assign rk        = rk_valid ? rk_mem[idx_reg] : '0;
    assign rk_round  = rk_valid ? idx_reg : 4'd0;
    assign rk_last   = rk_valid && (idx_reg == 4'd0);

endmodule

// File: tb/tb_dec_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_dec_key_schedule
//   Self-checking bench for dec_key_schedule. A behavioural model holds the
//   expected round keys in a queue, ordered as they must leave the block. The
//   keys come from a word-level key expansion that uses an S-box built from
//   GF(2^8) inversion plus the affine map. A compare thread checks all
//   outputs on every falling edge. Directed scenarios and a randomized phase
//   drive the DUT.
// ---------------------------------------------------------------------------

module tb_dec_key_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_valid;
    logic [127:0] key;
    logic         key_ready;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk;
    logic [3:0]   rk_round;
    logic         rk_last;

    int checks   = 0;
    int failures = 0;
    int dut_hs   = 0;

    int   ready_mode   = 0;     // 0: always ready, 1: random, 2: manual_ready
    logic manual_ready = 1'b1;

    logic [7:0]   sbox_m [256];
    logic [127:0] m_q [$];      // expected keys, in output order
    int           m_delay = 0;  // cycles of expansion still to go

    always #5 clk = ~clk;

    dec_key_schedule #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key       (key),
        .key_ready (key_ready),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_last   (rk_last)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] inv = 8'h01;
        if (a == 8'h00) inv = 8'h00;
        else for (int k = 0; k < 254; k++) inv = gmul(inv, a);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int r);
        logic [31:0] w [4];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int s = 1; s <= r; s++) begin
            t = {w[3][23:0], w[3][31:24]};
            t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
            t[31:24] = t[31:24] ^ rc;
            rc = xtime(rc);
            w[0] = w[0] ^ t;
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
        end
        return {w[0], w[1], w[2], w[3]};
    endfunction

    // ---------------- model and compare threads ----------------
    task automatic model_loop();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_delay = 0;
            end else if (m_q.size() == 0) begin
                if (key_valid) begin
                    for (int r = 10; r >= 0; r--) m_q.push_back(round_key(key, r));
                    m_delay = 10;
                end
            end else if (m_delay > 0) begin
                m_delay = m_delay - 1;
            end else if (rk_ready) begin
                void'(m_q.pop_front());
            end
        end
    endtask

    task automatic compare_loop();
        logic [134:0] act_v;
        logic [134:0] exp_v;
        logic         ev;
        forever begin
            @(negedge clk);
            ev    = (m_q.size() > 0) && (m_delay == 0);
            exp_v = {rst_n && (m_q.size() == 0), ev,
                     ev ? 4'(m_q.size() - 1) : 4'd0,
                     ev && (m_q.size() == 1),
                     ev ? m_q[0] : 128'd0};
            act_v = {key_ready, rk_valid, rk_round, rk_last, rk};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, act_v, exp_v);
            end
            if (rk_valid && rk_ready) dut_hs++;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        bit found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (key_ready) found = 1;
        end
        if (!found) check(name, 128'(0), 128'(1));
    endtask

    task automatic wait_round(input int r, input string name);
        bit found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (rk_valid && (rk_round == 4'(r))) found = 1;
        end
        if (!found) check(name, 128'(0), 128'(1));
    endtask

    task automatic send_key(input logic [127:0] k);
        wait_ready("send_key_timeout");
        tick();
        key_valid = 1'b1;
        key       = k;
        tick();
        key_valid = 1'b0;
    endtask

    // Falling edges from the current point until rk_valid is seen.
    task automatic measure(output int n);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (rk_valid) break;
        end
    endtask

    // ---------------- rk_ready driver ----------------
    initial begin
        rk_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       rk_ready = 1'b1;
                1:       rk_ready = 1'($urandom_range(0, 1));
                default: rk_ready = manual_ready;
            endcase
        end
    end

    // ---------------- main sequence ----------------
    localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;

    initial begin
        int           lat;
        int           bad;
        logic [127:0] held;
        logic [127:0] k_a;
        logic [127:0] k_b;

        rst_n     = 1'b0;
        key_valid = 1'b0;
        key       = '0;
        for (int a = 0; a < 256; a++) sbox_m[a] = sbox_calc(8'(a));

        fork
            model_loop();
            compare_loop();
        join_none

        // Pin the model to published values.
        check("model_fips_rk10", round_key(K_FIPS, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_fips_rk1",  round_key(K_FIPS, 1),  128'ha0fafe1788542cb123a339392a6c7605);
        check("model_seq_rk10",  round_key(K_SEQ, 10),  128'h13111d7fe3944a17f307a78b4d2b30c5);

        repeat (3) tick();
        @(negedge clk);
        check("key_ready_in_reset", 128'(key_ready), 128'(0));
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("key_ready_after_reset", 128'(key_ready), 128'(1));

        // FIPS-197 vector, continuous rk_ready.
        ready_mode = 0;
        send_key(K_FIPS);
        measure(lat);
        check("fips_latency", 128'(lat), 128'(11));
        check("fips_rk10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_round10", 128'(rk_round), 128'(10));
        wait_round(1, "fips_round1_timeout");
        check("fips_rk1", rk, 128'ha0fafe1788542cb123a339392a6c7605);
        @(negedge clk);
        check("fips_rk0", rk, K_FIPS);
        check("fips_last", 128'({rk_valid, rk_round, rk_last}), 128'({1'b1, 4'd0, 1'b1}));

        // Second vector: exactly eleven handshakes.
        wait_ready("seq_idle_timeout");
        dut_hs = 0;
        send_key(K_SEQ);
        measure(lat);
        check("seq_rk10", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        wait_round(0, "seq_round0_timeout");
        check("seq_rk0", rk, K_SEQ);
        wait_ready("seq_done_timeout");
        check("seq_handshakes", 128'(dut_hs), 128'(11));

        // Backpressure: five stalled cycles at round 7.
        k_a = {$urandom, $urandom, $urandom, $urandom};
        manual_ready = 1'b1;
        ready_mode   = 2;
        dut_hs       = 0;
        send_key(k_a);
        wait_round(8, "bp_round8_timeout");
        manual_ready = 1'b0;
        @(negedge clk);
        held = rk;
        check("bp_round7_key", held, round_key(k_a, 7));
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (rk !== held || rk_round !== 4'd7 || rk_ready !== 1'b0) bad++;
        end
        check("bp_stable", 128'(bad), 128'(0));
        manual_ready = 1'b1;
        wait_ready("bp_done_timeout");
        check("bp_handshakes", 128'(dut_hs), 128'(11));

        // Spurious keys during EXPAND and STREAM.
        ready_mode = 0;
        k_a = {$urandom, $urandom, $urandom, $urandom};
        k_b = {$urandom, $urandom, $urandom, $urandom};
        send_key(k_a);
        tick();
        key_valid = 1'b1;
        key       = k_b;
        @(negedge clk);
        check("spur_expand_key_ready", 128'(key_ready), 128'(0));
        tick();
        key_valid = 1'b0;
        wait_round(10, "spur_round10_timeout");
        check("spur_rk10", rk, round_key(k_a, 10));
        tick();
        key_valid = 1'b1;
        @(negedge clk);
        check("spur_stream_key_ready", 128'(key_ready), 128'(0));
        tick();
        key_valid = 1'b0;
        wait_round(0, "spur_round0_timeout");
        check("spur_rk0", rk, k_a);

        // Reset during STREAM at round 4.
        k_a = {$urandom, $urandom, $urandom, $urandom};
        send_key(k_a);
        wait_round(4, "rst_round4_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", 128'({key_ready, rk_valid, rk_round, rk_last, rk}), 128'(0));
        repeat (2) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_key_ready_after", 128'(key_ready), 128'(1));
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rk_valid !== 1'b0) bad++;
        end
        check("rst_no_stale_output", 128'(bad), 128'(0));

        // Back-to-back keys with key_valid held high.
        k_a = {$urandom, $urandom, $urandom, $urandom};
        k_b = {$urandom, $urandom, $urandom, $urandom};
        wait_ready("b2b_idle_timeout");
        tick();
        key_valid = 1'b1;
        key       = k_a;
        tick();
        key = k_b;
        wait_round(0, "b2b_round0_timeout");
        measure(lat);
        check("b2b_gap", 128'(lat), 128'(12));
        check("b2b_rk10", rk, round_key(k_b, 10));
        tick();
        key_valid = 1'b0;
        wait_ready("b2b_done_timeout");

        // Randomized traffic with occasional asynchronous reset pulses.
        ready_mode = 1;
        for (int c = 0; c < 2000; c++) begin
            tick();
            key_valid = ($urandom_range(0, 3) == 0);
            key       = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
        end
        tick();
        key_valid  = 1'b0;
        ready_mode = 0;
        wait_ready("random_drain_timeout");
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dec_key_schedule.md
DEC_KEY_SCHEDULE -- requirements
Module: dec_key_schedule

Interface
REQ-001 Parameter NR, default 10, is the AES-128 round count; 10 is the only supported value.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 key_valid  input  1  cipher key offered.
REQ-005 key  input  128  cipher key, byte 0 in bits [127:120].
REQ-006 key_ready  output  1  block can accept a key.
REQ-007 rk_valid  output  1  round key presented to the decryption round datapath.
REQ-008 rk_ready  input  1  round datapath consumes rk this cycle.
REQ-009 rk  output  128  round key, same byte order as key.
REQ-010 rk_round  output  4  index of the round key on rk, 10 down to 0.
REQ-011 rk_last  output  1  high with rk_valid when rk_round==0.

Function
REQ-012 The FSM SHALL have states IDLE, EXPAND and STREAM.
REQ-013 key_ready SHALL be 1 only in IDLE, with rst_n high.
REQ-014 IDLE: on key_valid&&key_ready, store key as round key 0, set cnt=1 and go to EXPAND.
REQ-015 EXPAND: each cycle store round key cnt, derived from round key cnt-1 by the FIPS-197 expansion.
- Expansion: RotWord, SubWord, XOR Rcon[cnt] into word 0, chained XOR for words 1-3.
- Then cnt++.
REQ-016 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36, in the top byte of the word.
REQ-017 SubWord SHALL use the team's forward sub_bytes module at 4-byte width; one expansion step per cycle, with no multicycle paths.
REQ-018 When round key 10 is written, the FSM SHALL go to STREAM with idx=10.
REQ-019 rk_valid SHALL first assert in the 11th cycle after the key-accept cycle; EXPAND lasts exactly 10 cycles.
REQ-020 STREAM: rk_valid=1, rk=stored round key[idx], rk_round=idx.
REQ-021 While rk_valid&&!rk_ready, rk, rk_round and rk_last SHALL hold stable.
REQ-022 On rk_valid&&rk_ready with idx>0, idx SHALL decrement; one key per cycle under continuous rk_ready.
REQ-023 On rk_valid&&rk_ready with idx==0, the FSM SHALL return to IDLE.
- key_ready asserts the next cycle.
- A new key may be accepted in that cycle.
REQ-024 When rk_valid is 0, rk, rk_round and rk_last SHALL be driven 0.
REQ-025 key_valid in EXPAND or STREAM SHALL be ignored, with no state change.
REQ-026 rk_ready outside STREAM SHALL be ignored.
REQ-027 Round keys are plain expansion output; no InvMixColumns is applied, because AddRoundKey precedes InvMixColumns in the round stage.
REQ-028 All arithmetic is GF(2^8) XOR/S-box only; cnt and idx are 4-bit and never wrap past 10 or below 0.

Reset
REQ-029 rst_n low SHALL immediately force the FSM to IDLE, independent of clk.
REQ-030 rst_n low SHALL immediately force cnt=0, idx=0, rk_valid=0, rk=0, rk_round=0, rk_last=0 and key_ready=0.
REQ-031 rst_n low SHALL clear the round-key storage to 0.
REQ-032 Reset asserted mid-EXPAND or mid-STREAM SHALL abort the operation; no partial key is emitted after release.
REQ-033 key_ready SHALL be 1 in the first cycle after rst_n deasserts.

Verification
REQ-034 FIPS-197 vector: key=2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1.
- rk_valid rises 11 cycles after accept.
- Sequence: rk_round 10 rk=d014f9a8c9ee2589e13f0cc8b6630ca6, ..., rk_round 1 rk=a0fafe1788542cb123a339392a6c7605, rk_round 0 rk=key with rk_last=1.
REQ-035 key=000102030405060708090a0b0c0d0e0f:
- First rk=13111d7fe3944a17f307a78b4d2b30c5.
- Last rk=000102030405060708090a0b0c0d0e0f.
- Exactly 11 handshakes.
REQ-036 Backpressure: hold rk_ready=0 for 5 cycles at rk_round 7, then release.
- rk and rk_round stay stable throughout.
- No key is skipped or repeated.
REQ-037 Assert key_valid with a different key during EXPAND and during STREAM.
- key_ready stays 0.
- The output sequence matches the first key only.
REQ-038 Pulse rst_n low during STREAM at rk_round 4.
- rk_valid drops asynchronously.
- After release, key_ready=1 and rk_valid stays 0 until a new key completes expansion.
REQ-039 Back-to-back: with key_valid held high and a new key present at the final handshake, the second key is accepted in the cycle after rk_last.
- Its rk_round 10 appears 11 cycles later.
